// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: counting mode
// encodings and the up/down direction type used by the center-aligned counter.
package pwm_pkg;

  // Counting mode encodings as seen on the mode input and in the mode shadow.
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Direction of the shared period counter. Edge mode always counts up.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output channel. Holds its own shadowed compare value and polarity,
// compares them against the shared counter, and registers the output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] cmp_in,
  input  logic             pol_in,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] cmp_sh;
  logic             pol_sh;
  logic             act;

  // The channel is active while the counter is below the compare value.
  // A compare of 0 is never active; one above the period is always active.
  assign act = (cnt < cmp_sh);

  // Shadow copies only change on the update point chosen by the top level,
  // so a compare written mid-period cannot produce a runt pulse.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cmp_sh <= '0;
      pol_sh <= 1'b0;
    end else if (load) begin
      cmp_sh <= cmp_in;
      pol_sh <= pol_in;
    end
  end

  // Registered output: idle level when halted, polarity-adjusted compare otherwise.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pwm <= 1'b0;
    end else if (en) begin
      pwm <= act ^ pol_sh;
    end else begin
      pwm <= pol_sh;
    end
  end

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator. A single period counter (edge- or
// center-aligned) is shared by CHANNELS comparators; period, mode, compare
// and polarity are shadowed so changes only take effect at a period boundary.
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      en,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] cmp,
  input  logic [CHANNELS-1:0]       pol,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick,
  output logic [WIDTH-1:0]          cnt
);

  logic [WIDTH-1:0] period_sh;
  logic             mode_sh;
  dir_t             dir;

  logic [WIDTH-1:0] cnt_next;
  dir_t             dir_next;
  logic             load;
  logic             tick_next;

  // Next counter value and direction. Comparisons are made against the
  // current value before stepping, so a period of all ones never overflows.
  // Whenever the counter is about to return to 0 the direction resets to up,
  // which keeps a mode change at the update point clean.
  always_comb begin
    cnt_next = '0;
    dir_next = DIR_UP;
    if (en && (period_sh != '0)) begin
      if (mode_sh == MODE_EDGE) begin
        if (cnt >= period_sh) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt + WIDTH'(1);
        end
        dir_next = DIR_UP;
      end else begin
        if (dir == DIR_UP) begin
          if (cnt >= period_sh) begin
            cnt_next = cnt - WIDTH'(1);
            dir_next = DIR_DOWN;
          end else begin
            cnt_next = cnt + WIDTH'(1);
            dir_next = DIR_UP;
          end
        end else begin
          if (cnt == '0) begin
            cnt_next = '0;
          end else begin
            cnt_next = cnt - WIDTH'(1);
          end
          dir_next = DIR_DOWN;
        end
        if (cnt_next == '0) begin
          dir_next = DIR_UP;
        end
      end
    end
  end

  // Shadows follow the inputs while halted and otherwise refresh only on the
  // cycle that starts a new period; the tick marks that same boundary.
  assign load      = !en || (cnt_next == '0);
  assign tick_next = en && (cnt_next == '0) && ((cnt != '0) || (period_sh == '0));

  // Counter, direction state and period tick.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt         <= '0;
      dir         <= DIR_UP;
      period_tick <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      dir         <= dir_next;
      period_tick <= tick_next;
    end
  end

  // Shadow copies of the period and counting mode.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      period_sh <= '0;
      mode_sh   <= MODE_EDGE;
    end else if (load) begin
      period_sh <= period;
      mode_sh   <= mode;
    end
  end

  // One comparator/output stage per channel, all sharing the counter.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk   (clk),
      .res   (res),
      .en    (en),
      .load  (load),
      .cmp_in(cmp[k*WIDTH +: WIDTH]),
      .pol_in(pol[k]),
      .cnt   (cnt),
      .pwm   (pwm_out[k])
    );
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen: a phase-based reference model
// predicts cnt, pwm_out and period_tick each cycle through a scoreboard,
// plus directed duty-cycle and tick counts over whole periods.
module tb_pwm_multi_gen;
  import pwm_pkg::*;

  localparam int W  = 8;
  localparam int CH = 4;

  logic              clk = 1'b0;
  logic              res;
  logic              en;
  logic              mode;
  logic [W-1:0]      period;
  logic [CH*W-1:0]   cmp;
  logic [CH-1:0]     pol;
  logic [CH-1:0]     pwm_out;
  logic              period_tick;
  logic [W-1:0]      cnt;

  typedef struct {
    logic [W-1:0]  cnt;
    logic [CH-1:0] pwm;
    logic          tick;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  int            m_phase;
  int            m_per;
  logic          m_mode;
  int            m_cmp[CH];
  logic [CH-1:0] m_pol;
  int            high_cnt[CH];
  int            tick_cnt;

  pwm_multi_gen #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk        (clk),
    .res        (res),
    .en         (en),
    .mode       (mode),
    .period     (period),
    .cmp        (cmp),
    .pol        (pol),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .cnt        (cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int cnt_of(input int ph, input int per, input logic md);
    if (md && (ph > per)) return 2 * per - ph;
    return ph;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_per   = 0;
    m_mode  = 1'b0;
    m_pol   = '0;
    for (int k = 0; k < CH; k++) m_cmp[k] = 0;
    sb_q.delete();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < CH; k++) high_cnt[k] = 0;
    tick_cnt = 0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    tests++;
    assert (obs === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expected);
    end
  endtask

  // Predict the post-edge outputs from the driven inputs, advance one clock,
  // then compare the DUT against the prediction taken from the scoreboard.
  task automatic applyStimulus();
    exp_t e;
    int   plen;
    int   cur;
    int   nph;
    logic ld;
    cur = cnt_of(m_phase, m_per, m_mode);
    e.pwm = '0;
    if (!en) begin
      e.tick = 1'b0;
      e.pwm  = m_pol;
      nph    = 0;
      ld     = 1'b1;
    end else begin
      plen = (m_per == 0) ? 1 : (m_mode ? 2 * m_per : m_per + 1);
      nph  = (m_phase + 1) % plen;
      for (int k = 0; k < CH; k++) e.pwm[k] = ((cur < m_cmp[k]) ? 1'b1 : 1'b0) ^ m_pol[k];
      e.tick = (nph == 0);
      ld     = (nph == 0);
    end
    if (ld) begin
      m_per  = int'(period);
      m_mode = mode;
      m_pol  = pol;
      for (int k = 0; k < CH; k++) m_cmp[k] = int'(cmp[k*W +: W]);
    end
    m_phase = nph;
    e.cnt   = W'(cnt_of(nph, m_per, m_mode));
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checkOutput("cnt", cnt, e.cnt);
    checkOutput("pwm_out", pwm_out, e.pwm);
    checkOutput("period_tick", period_tick, e.tick);
    for (int k = 0; k < CH; k++) high_cnt[k] += int'(pwm_out[k]);
    tick_cnt += int'(period_tick);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Step until the model says the counter holds the target value.
  task automatic wait_cnt(input string tag, input int target, input int limit);
    int i;
    i = 0;
    while ((cnt_of(m_phase, m_per, m_mode) != target) && (i < limit)) begin
      applyStimulus();
      i++;
    end
    checkOutput(tag, (i < limit) ? 1 : 0, 1);
  endtask

  initial begin
    res    = 1'b0;
    en     = 1'b0;
    mode   = MODE_EDGE;
    period = '0;
    cmp    = '0;
    pol    = '0;
    model_reset();
    clear_counts();
    #12;
    checkOutput("reset_cnt", cnt, 0);
    checkOutput("reset_pwm", pwm_out, 0);
    checkOutput("reset_tick", period_tick, 0);
    res = 1'b1;

    // Edge mode, period 9, compares 0/3/5/12.
    period = 8'd9;
    cmp    = {8'd12, 8'd5, 8'd3, 8'd0};
    applyStimulus();
    en = 1'b1;
    run(12);
    clear_counts();
    run(10);
    checkOutput("edge_high0", high_cnt[0], 0);
    checkOutput("edge_high1", high_cnt[1], 3);
    checkOutput("edge_high2", high_cnt[2], 5);
    checkOutput("edge_high3", high_cnt[3], 10);
    checkOutput("edge_ticks", tick_cnt, 1);

    // Mid-period compare write takes effect only from the next period.
    wait_cnt("wait_cnt4", 4, 20);
    cmp[15:8] = 8'd7;
    clear_counts();
    wait_cnt("wait_wrap", 0, 20);
    checkOutput("old_width_rest", high_cnt[1], 0);
    clear_counts();
    run(10);
    checkOutput("new_width", high_cnt[1], 7);

    // Center mode, period 4, compare 2 on channel 0.
    mode     = MODE_CENTER;
    period   = 8'd4;
    cmp[7:0] = 8'd2;
    wait_cnt("wait_center", 0, 20);
    run(16);
    clear_counts();
    run(8);
    checkOutput("center_high0", high_cnt[0], 3);
    checkOutput("center_ticks", tick_cnt, 1);

    // Idle level with inverted channel 2, then first period after enabling.
    en       = 1'b0;
    mode     = MODE_EDGE;
    period   = 8'd9;
    cmp[7:0] = 8'd0;
    pol      = 4'b0100;
    run(3);
    checkOutput("idle_pol", pwm_out, 4'b0100);
    en = 1'b1;
    clear_counts();
    run(10);
    checkOutput("inv_high2", high_cnt[2], 5);
    checkOutput("inv_high1", high_cnt[1], 7);

    // Full-range period: clean 255 -> 0 wrap.
    en     = 1'b0;
    pol    = '0;
    period = 8'd255;
    cmp    = {4{8'd255}};
    applyStimulus();
    en = 1'b1;
    run(300);
    clear_counts();
    run(256);
    checkOutput("wrap_high0", high_cnt[0], 255);
    checkOutput("wrap_ticks", tick_cnt, 1);

    // Asynchronous reset in the middle of a clock cycle.
    en     = 1'b0;
    period = 8'd9;
    cmp    = {8'd12, 8'd5, 8'd3, 8'd0};
    applyStimulus();
    en = 1'b1;
    wait_cnt("wait_cnt6", 6, 20);
    #3;
    res = 1'b0;
    #1;
    checkOutput("async_cnt", cnt, 0);
    checkOutput("async_pwm", pwm_out, 0);
    checkOutput("async_tick", period_tick, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_cnt", cnt, 0);
    res = 1'b1;
    run(25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
